// File: rtl/exception_unit_pkg.sv
// exception_unit_pkg
// Shared constants for the exception unit and its CSR file: machine-mode CSR
// addresses, mcause codes, bit positions inside mstatus/mie/mip, the bit
// indices of the exception vector, and the Zicsr operation encoding taken
// from funct3[1:0].
package exception_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
   localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
   localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
   localparam logic [31:0] CAUSE_ECALL       = 32'd11;
   localparam logic [31:0] CAUSE_EXT_INT     = 32'h8000_000B;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MEIE     = 11;
   localparam int MIP_MEIP     = 11;

   // MPP is hardwired to machine mode and always reads back as 2'b11
   localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

   localparam int EXP_ILLEGAL = 0;
   localparam int EXP_ECALL   = 1;
   localparam int EXP_FAULT   = 2;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

endpackage

// File: rtl/exception_unit_csr_regfile.sv
// csr_regfile
// Machine-mode CSR storage with a combinational read mux and RW/RS/RC write
// logic. A trap or mret update port overrides any software write to the
// registers it touches.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   csr_addr_i         addressed CSR
//   csr_op_i           RW/RS/RC selector
//   operand_i          zimm or rs1 value
//   rs1_zero_i         rs1 index/zimm is zero (RS/RC then do not write)
//   csr_we_i           software write permitted this cycle
//   trap_i             trap taken; load mepc/mcause/mtval and stack MIE
//   trap_epc_i, trap_cause_i, trap_tval_i   values captured on a trap
//   mret_i             mret taken; restore MIE from MPIE
//   pending_i          external interrupt pending, shown as mip.MEIP
//   rdata_o            current value of the addressed CSR
//   mtvec_o, mepc_o    trap vector and return address
//   mstatus_mie_o, mie_meie_o   interrupt enable bits
module csr_regfile
   import exception_unit_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] csr_addr_i,
   input  csr_op_e     csr_op_i,
   input  logic [31:0] operand_i,
   input  logic        rs1_zero_i,
   input  logic        csr_we_i,
   input  logic        trap_i,
   input  logic [31:0] trap_epc_i,
   input  logic [31:0] trap_cause_i,
   input  logic [31:0] trap_tval_i,
   input  logic        mret_i,
   input  logic        pending_i,
   output logic [31:0] rdata_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        mstatus_mie_o,
   output logic        mie_meie_o
);

   logic        mstatusMie_q, mstatusMie_d;
   logic        mstatusMpie_q, mstatusMpie_d;
   logic        mieMeie_q, mieMeie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] writeData;
   logic        writeEn;

   // Read mux: unimplemented addresses read as zero. mstatus is rebuilt from
   // its two writable bits plus the hardwired MPP field.
   always_comb begin
      rdata_o = 32'h0;
      case (csr_addr_i)
         CSR_MSTATUS:  rdata_o = MSTATUS_MPP_M
                                 | (32'(mstatusMpie_q) << MSTATUS_MPIE)
                                 | (32'(mstatusMie_q) << MSTATUS_MIE);
         CSR_MIE:      rdata_o = 32'(mieMeie_q) << MIE_MEIE;
         CSR_MTVEC:    rdata_o = mtvec_q;
         CSR_MSCRATCH: rdata_o = mscratch_q;
         CSR_MEPC:     rdata_o = mepc_q;
         CSR_MCAUSE:   rdata_o = mcause_q;
         CSR_MTVAL:    rdata_o = mtval_q;
         CSR_MIP:      rdata_o = 32'(pending_i) << MIP_MEIP;
         default:      rdata_o = 32'h0;
      endcase
   end

   // Compute the merged write value; set/clear with a zero rs1 field is a
   // pure read and must not write, even though the merge would be harmless,
   // so that read-only side effects are never triggered.
   always_comb begin
      writeData = operand_i;
      writeEn   = csr_we_i;
      case (csr_op_i)
         CSR_OP_RW: writeData = operand_i;
         CSR_OP_RS: begin
            writeData = rdata_o | operand_i;
            writeEn   = csr_we_i & ~rs1_zero_i;
         end
         CSR_OP_RC: begin
            writeData = rdata_o & ~operand_i;
            writeEn   = csr_we_i & ~rs1_zero_i;
         end
         default:   writeEn = 1'b0;
      endcase
   end

   // Next-state selection: trap entry and mret take precedence over any
   // software write, and alignment bits of mtvec/mepc are forced to zero.
   always_comb begin
      mstatusMie_d  = mstatusMie_q;
      mstatusMpie_d = mstatusMpie_q;
      mieMeie_d     = mieMeie_q;
      mtvec_d       = mtvec_q;
      mscratch_d    = mscratch_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      if (trap_i) begin
         mstatusMpie_d = mstatusMie_q;
         mstatusMie_d  = 1'b0;
         mepc_d        = trap_epc_i & 32'hFFFF_FFFC;
         mcause_d      = trap_cause_i;
         mtval_d       = trap_tval_i;
      end else if (mret_i) begin
         mstatusMie_d  = mstatusMpie_q;
         mstatusMpie_d = 1'b1;
      end else if (writeEn) begin
         case (csr_addr_i)
            CSR_MSTATUS: begin
               mstatusMie_d  = writeData[MSTATUS_MIE];
               mstatusMpie_d = writeData[MSTATUS_MPIE];
            end
            CSR_MIE:      mieMeie_d  = writeData[MIE_MEIE];
            CSR_MTVEC:    mtvec_d    = writeData & 32'hFFFF_FFFC;
            CSR_MSCRATCH: mscratch_d = writeData;
            CSR_MEPC:     mepc_d     = writeData & 32'hFFFF_FFFC;
            CSR_MCAUSE:   mcause_d   = writeData;
            CSR_MTVAL:    mtval_d    = writeData;
            default:      ;
         endcase
      end
   end

   // CSR state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatusMie_q  <= 1'b0;
         mstatusMpie_q <= 1'b0;
         mieMeie_q     <= 1'b0;
         mtvec_q       <= MTVEC_RESET;
         mscratch_q    <= 32'h0;
         mepc_q        <= 32'h0;
         mcause_q      <= 32'h0;
         mtval_q       <= 32'h0;
      end else begin
         mstatusMie_q  <= mstatusMie_d;
         mstatusMpie_q <= mstatusMpie_d;
         mieMeie_q     <= mieMeie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
      end
   end

   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;
   assign mstatus_mie_o = mstatusMie_q;
   assign mie_meie_o    = mieMeie_q;

endmodule

// File: rtl/exception_unit.sv
// exception_unit
// Consumes the exception/CSR fields of the instruction in MEM, owns the
// machine-mode CSR file and the external-interrupt pending latch, and decides
// trap entry or mret. Redirect and flush outputs are combinational on the MEM
// inputs; all state changes land on the closing clock edge.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   interrupt                level external interrupt, synchronous to clk
//   exp_vector_MEM           [0] illegal, [1] ecall, [2] access fault
//   mret_MEM, csr_rw_MEM     MEM instruction is mret / Zicsr op
//   csr_w_imm_mux_MEM        Zicsr operand is zimm (1) or rs1 value (0)
//   mem_r_MEM                MEM instruction is a load
//   isFlushed                MEM slot holds a bubble
//   IR_MEM, PCurrent_MEM, ALUO_MEM, rs1_MEM, rs1_data_MEM   MEM operands
//   csr_r_data               old CSR value for writeback
//   redirect_mux, PC_redirect    fetch redirect and its target
//   reg_FD/DE/EM/MW_flush    pipeline latch flushes
//   mem_w_cancel             suppress the MEM data-memory write
module exception_unit
   import exception_unit_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interrupt,
   input  logic [2:0]  exp_vector_MEM,
   input  logic        mret_MEM,
   input  logic        csr_rw_MEM,
   input  logic        csr_w_imm_mux_MEM,
   input  logic        mem_r_MEM,
   input  logic        isFlushed,
   input  logic [31:0] IR_MEM,
   input  logic [31:0] PCurrent_MEM,
   input  logic [31:0] ALUO_MEM,
   input  logic [4:0]  rs1_MEM,
   input  logic [31:0] rs1_data_MEM,
   output logic [31:0] csr_r_data,
   output logic        redirect_mux,
   output logic [31:0] PC_redirect,
   output logic        reg_FD_flush,
   output logic        reg_DE_flush,
   output logic        reg_EM_flush,
   output logic        reg_MW_flush,
   output logic        mem_w_cancel
);

   logic        int_q;
   logic        pending_q, pending_d;
   logic        slotValid, excAny, intTake, trapTake, mretTake, csrWe;
   logic [31:0] trapCause, trapTval;
   logic [31:0] mtvec, mepc, csrOperand;
   logic        mstatusMie, mieMeie;

   assign slotValid  = ~isFlushed;
   assign excAny     = slotValid & (|exp_vector_MEM);
   assign csrOperand = csr_w_imm_mux_MEM ? {27'h0, rs1_MEM} : rs1_data_MEM;

   // Trap priority: synchronous exceptions in fixed order, then the external
   // interrupt. An interrupt is held off on an mret so the return completes
   // first. Nothing is taken while reset is asserted.
   always_comb begin
      trapCause = 32'h0;
      trapTval  = 32'h0;
      intTake   = 1'b0;
      if (exp_vector_MEM[EXP_ILLEGAL]) begin
         trapCause = CAUSE_ILLEGAL;
         trapTval  = IR_MEM;
      end else if (exp_vector_MEM[EXP_ECALL]) begin
         trapCause = CAUSE_ECALL;
      end else if (exp_vector_MEM[EXP_FAULT]) begin
         trapCause = mem_r_MEM ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
         trapTval  = ALUO_MEM;
      end else begin
         trapCause = CAUSE_EXT_INT;
         intTake   = ~rst & pending_q & mstatusMie & mieMeie
                     & slotValid & ~mret_MEM;
      end
      trapTake = ~rst & (excAny | intTake);
      mretTake = ~rst & slotValid & mret_MEM & ~excAny;
      csrWe    = ~rst & slotValid & csr_rw_MEM & ~trapTake;
   end

   // Redirect and flush outputs. A trap kills everything including the MEM
   // instruction; mret only kills the younger instructions behind it.
   always_comb begin
      redirect_mux = 1'b0;
      PC_redirect  = 32'h0;
      reg_FD_flush = 1'b0;
      reg_DE_flush = 1'b0;
      reg_EM_flush = 1'b0;
      reg_MW_flush = 1'b0;
      mem_w_cancel = 1'b0;
      if (trapTake) begin
         redirect_mux = 1'b1;
         PC_redirect  = mtvec;
         reg_FD_flush = 1'b1;
         reg_DE_flush = 1'b1;
         reg_EM_flush = 1'b1;
         reg_MW_flush = 1'b1;
         mem_w_cancel = 1'b1;
      end else if (mretTake) begin
         redirect_mux = 1'b1;
         PC_redirect  = mepc;
         reg_FD_flush = 1'b1;
         reg_DE_flush = 1'b1;
         reg_EM_flush = 1'b1;
      end
   end

   // Pending latch: a rising edge always sets it, even when an interrupt trap
   // is being taken in the same cycle, so that edge is not lost.
   always_comb begin
      pending_d = pending_q;
      if (interrupt & ~int_q) begin
         pending_d = 1'b1;
      end else if (intTake) begin
         pending_d = 1'b0;
      end
   end

   // Interrupt edge detector and pending register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         int_q     <= interrupt;
         pending_q <= pending_d;
      end
   end

   csr_regfile #(
      .MTVEC_RESET (MTVEC_RESET)
   ) uCsrRegfile (
      .clk           (clk),
      .rst           (rst),
      .csr_addr_i    (IR_MEM[31:20]),
      .csr_op_i      (csr_op_e'(IR_MEM[13:12])),
      .operand_i     (csrOperand),
      .rs1_zero_i    (rs1_MEM == 5'd0),
      .csr_we_i      (csrWe),
      .trap_i        (trapTake),
      .trap_epc_i    (PCurrent_MEM),
      .trap_cause_i  (trapCause),
      .trap_tval_i   (trapTval),
      .mret_i        (mretTake),
      .pending_i     (pending_q),
      .rdata_o       (csr_r_data),
      .mtvec_o       (mtvec),
      .mepc_o        (mepc),
      .mstatus_mie_o (mstatusMie),
      .mie_meie_o    (mieMeie)
   );

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit
// Directed bench for exception_unit. Expected values are pushed into a
// scoreboard queue as each step is driven and popped when the DUT output is
// sampled, mid-cycle, away from the rising edge.
module tb_exception_unit;
   import exception_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        interrupt;
   logic [2:0]  exp_vector_MEM;
   logic        mret_MEM, csr_rw_MEM, csr_w_imm_mux_MEM, mem_r_MEM, isFlushed;
   logic [31:0] IR_MEM, PCurrent_MEM, ALUO_MEM, rs1_data_MEM;
   logic [4:0]  rs1_MEM;
   logic [31:0] csr_r_data, PC_redirect;
   logic        redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush;
   logic        reg_MW_flush, mem_w_cancel;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } expItem_t;

   expItem_t scoreboard[$];
   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   exception_unit #(.MTVEC_RESET(32'h0000_0008)) dut (
      .clk               (clk),
      .rst               (rst),
      .interrupt         (interrupt),
      .exp_vector_MEM    (exp_vector_MEM),
      .mret_MEM          (mret_MEM),
      .csr_rw_MEM        (csr_rw_MEM),
      .csr_w_imm_mux_MEM (csr_w_imm_mux_MEM),
      .mem_r_MEM         (mem_r_MEM),
      .isFlushed         (isFlushed),
      .IR_MEM            (IR_MEM),
      .PCurrent_MEM      (PCurrent_MEM),
      .ALUO_MEM          (ALUO_MEM),
      .rs1_MEM           (rs1_MEM),
      .rs1_data_MEM      (rs1_data_MEM),
      .csr_r_data        (csr_r_data),
      .redirect_mux      (redirect_mux),
      .PC_redirect       (PC_redirect),
      .reg_FD_flush      (reg_FD_flush),
      .reg_DE_flush      (reg_DE_flush),
      .reg_EM_flush      (reg_EM_flush),
      .reg_MW_flush      (reg_MW_flush),
      .mem_w_cancel      (mem_w_cancel)
   );

   always #5 clk = ~clk;

   // Zicsr encoding: csr[31:20], rs1[19:15], funct3[14:12], rd=x1, SYSTEM
   function automatic logic [31:0] csrIr(input logic [11:0] addr,
                                         input logic [2:0] f3,
                                         input logic [4:0] rs1);
      return {addr, rs1, f3, 5'd1, 7'b1110011};
   endfunction

   // Bubble in MEM, no flags; the interrupt line is left alone
   task automatic setIdle();
      exp_vector_MEM    = 3'b000;
      mret_MEM          = 1'b0;
      csr_rw_MEM        = 1'b0;
      csr_w_imm_mux_MEM = 1'b0;
      mem_r_MEM         = 1'b0;
      isFlushed         = 1'b1;
      IR_MEM            = 32'h0000_0013;
      PCurrent_MEM      = 32'h0;
      ALUO_MEM          = 32'h0;
      rs1_MEM           = 5'd0;
      rs1_data_MEM      = 32'h0;
   endtask

   task automatic pushExp(input string tag, input logic [31:0] value);
      expItem_t item;
      item.tag   = tag;
      item.value = value;
      scoreboard.push_back(item);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed);
      expItem_t item;
      checkCount++;
      if (scoreboard.size() == 0) begin
         failCount++;
         $error("[TB] FAIL %s: observed %h but scoreboard empty", tag, observed);
      end else begin
         item = scoreboard.pop_front();
         assert (observed === item.value) passCount++;
         else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", item.tag, observed, item.value);
         end
      end
   endtask

   // Read a CSR from a bubble slot so no write or trap can happen
   task automatic readCsr(input logic [11:0] addr, input logic [31:0] expected,
                          input string tag);
      @(negedge clk);
      setIdle();
      csr_rw_MEM = 1'b1;
      IR_MEM     = csrIr(addr, 3'b010, 5'd0);
      pushExp(tag, expected);
      #2;
      checkOutput(tag, csr_r_data);
   endtask

   // Valid Zicsr op: checks the returned old value and that no redirect occurs
   task automatic applyStimulus(input logic [11:0] addr, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic [31:0] data,
                                input logic imm, input logic [31:0] expOld,
                                input string tag);
      @(negedge clk);
      setIdle();
      isFlushed         = 1'b0;
      csr_rw_MEM        = 1'b1;
      csr_w_imm_mux_MEM = imm;
      IR_MEM            = csrIr(addr, f3, rs1);
      rs1_MEM           = rs1;
      rs1_data_MEM      = data;
      PCurrent_MEM      = 32'h0000_0500;
      pushExp({tag, "_old"}, expOld);
      pushExp({tag, "_noredir"}, 32'h0);
      #2;
      checkOutput({tag, "_old"}, csr_r_data);
      checkOutput({tag, "_noredir"}, 32'(redirect_mux));
   endtask

   // Trap outputs in the cycle the trapping instruction sits in MEM
   task automatic checkTrapOutputs(input string tag);
      pushExp({tag, "_redir"}, 32'h1);
      pushExp({tag, "_target"}, 32'h0000_0008);
      pushExp({tag, "_flushes"}, 32'hF);
      pushExp({tag, "_wcancel"}, 32'h1);
      #2;
      checkOutput({tag, "_redir"}, 32'(redirect_mux));
      checkOutput({tag, "_target"}, PC_redirect);
      checkOutput({tag, "_flushes"},
                  {28'h0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush});
      checkOutput({tag, "_wcancel"}, 32'(mem_w_cancel));
   endtask

   initial begin
      rst       = 1'b1;
      interrupt = 1'b0;
      setIdle();
      // an exception presented during reset must not redirect
      exp_vector_MEM = 3'b001;
      isFlushed      = 1'b0;
      pushExp("rst_noredir", 32'h0);
      pushExp("rst_noflush", 32'h0);
      #2;
      checkOutput("rst_noredir", 32'(redirect_mux));
      checkOutput("rst_noflush", {31'h0, reg_MW_flush});
      @(negedge clk);
      setIdle();
      rst = 1'b0;

      // reset values read through CSRRS x0
      applyStimulus(CSR_MTVEC, 3'b010, 5'd0, 32'h0, 1'b0, 32'h0000_0008, "rd_mtvec");
      applyStimulus(CSR_MSTATUS, 3'b010, 5'd0, 32'h0, 1'b0, 32'h0000_1800, "rd_mstatus");

      // illegal instruction
      @(negedge clk);
      setIdle();
      isFlushed      = 1'b0;
      exp_vector_MEM = 3'b001;
      IR_MEM         = 32'hFFFF_FFFF;
      PCurrent_MEM   = 32'h0000_0040;
      checkTrapOutputs("illegal");
      readCsr(CSR_MEPC, 32'h0000_0040, "illegal_mepc");
      readCsr(CSR_MCAUSE, 32'd2, "illegal_mcause");
      readCsr(CSR_MTVAL, 32'hFFFF_FFFF, "illegal_mtval");

      // enable MIE (CSRRSI) and MEIE (CSRRS)
      applyStimulus(CSR_MSTATUS, 3'b110, 5'd8, 32'h0, 1'b1, 32'h0000_1800, "set_mie");
      applyStimulus(CSR_MIE, 3'b010, 5'd5, 32'h0000_0800, 1'b0, 32'h0, "set_meie");

      // raise the interrupt and hold it high
      @(negedge clk);
      setIdle();
      interrupt = 1'b1;
      readCsr(CSR_MIP, 32'h0000_0800, "int_pending");
      @(negedge clk);
      setIdle();
      isFlushed    = 1'b0;
      PCurrent_MEM = 32'h0000_0100;
      checkTrapOutputs("int");
      readCsr(CSR_MCAUSE, 32'h8000_000B, "int_mcause");
      readCsr(CSR_MEPC, 32'h0000_0100, "int_mepc");
      readCsr(CSR_MSTATUS, 32'h0000_1880, "int_mstatus");
      readCsr(CSR_MIP, 32'h0, "int_cleared");

      // re-enable MIE with the line still high: no new edge, no second trap
      applyStimulus(CSR_MSTATUS, 3'b110, 5'd8, 32'h0, 1'b1, 32'h0000_1880, "reenable");
      @(negedge clk);
      setIdle();
      isFlushed    = 1'b0;
      PCurrent_MEM = 32'h0000_0104;
      pushExp("no_second_trap", 32'h0);
      #2;
      checkOutput("no_second_trap", 32'(redirect_mux));

      // mret with mepc=0x104, MPIE=1, MIE=0
      applyStimulus(CSR_MSTATUS, 3'b111, 5'd8, 32'h0, 1'b1, 32'h0000_1888, "clr_mie");
      applyStimulus(CSR_MEPC, 3'b001, 5'd2, 32'h0000_0104, 1'b0, 32'h0000_0100, "wr_mepc");
      @(negedge clk);
      setIdle();
      isFlushed    = 1'b0;
      mret_MEM     = 1'b1;
      PCurrent_MEM = 32'h0000_0180;
      pushExp("mret_redir", 32'h1);
      pushExp("mret_target", 32'h0000_0104);
      pushExp("mret_flushes", 32'hE);
      pushExp("mret_wcancel", 32'h0);
      #2;
      checkOutput("mret_redir", 32'(redirect_mux));
      checkOutput("mret_target", PC_redirect);
      checkOutput("mret_flushes",
                  {28'h0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush});
      checkOutput("mret_wcancel", 32'(mem_w_cancel));
      readCsr(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");

      // new interrupt edge, then ecall + csr write to mscratch in one slot
      @(negedge clk);
      setIdle();
      interrupt = 1'b0;
      @(negedge clk);
      interrupt = 1'b1;
      readCsr(CSR_MIP, 32'h0000_0800, "pend2");
      @(negedge clk);
      setIdle();
      isFlushed      = 1'b0;
      exp_vector_MEM = 3'b010;
      csr_rw_MEM     = 1'b1;
      IR_MEM         = csrIr(CSR_MSCRATCH, 3'b001, 5'd3);
      rs1_MEM        = 5'd3;
      rs1_data_MEM   = 32'hDEAD_BEEF;
      PCurrent_MEM   = 32'h0000_0200;
      checkTrapOutputs("ecall");
      readCsr(CSR_MCAUSE, 32'd11, "ecall_mcause");
      readCsr(CSR_MTVAL, 32'h0, "ecall_mtval");
      readCsr(CSR_MSCRATCH, 32'h0, "ecall_mscratch");
      readCsr(CSR_MIP, 32'h0000_0800, "ecall_pending");
      readCsr(CSR_MEPC, 32'h0000_0200, "ecall_mepc");
      readCsr(CSR_MSTATUS, 32'h0000_1880, "ecall_mstatus");

      // illegal beats ecall when both flags are set
      @(negedge clk);
      setIdle();
      isFlushed      = 1'b0;
      exp_vector_MEM = 3'b011;
      IR_MEM         = 32'hDEAD_0000;
      PCurrent_MEM   = 32'h0000_0210;
      checkTrapOutputs("prio");
      readCsr(CSR_MCAUSE, 32'd2, "prio_mcause");
      readCsr(CSR_MTVAL, 32'hDEAD_0000, "prio_mtval");

      // store and load access faults
      @(negedge clk);
      setIdle();
      isFlushed      = 1'b0;
      exp_vector_MEM = 3'b100;
      ALUO_MEM       = 32'h2000_0003;
      PCurrent_MEM   = 32'h0000_0300;
      checkTrapOutputs("store_fault");
      readCsr(CSR_MCAUSE, 32'd7, "store_mcause");
      readCsr(CSR_MTVAL, 32'h2000_0003, "store_mtval");
      @(negedge clk);
      setIdle();
      isFlushed      = 1'b0;
      exp_vector_MEM = 3'b100;
      mem_r_MEM      = 1'b1;
      ALUO_MEM       = 32'h0000_0044;
      PCurrent_MEM   = 32'h0000_0306;
      checkTrapOutputs("load_fault");
      readCsr(CSR_MCAUSE, 32'd5, "load_mcause");
      readCsr(CSR_MEPC, 32'h0000_0304, "load_mepc_align");

      // CSRRC with rs1=0 leaves the CSR alone
      applyStimulus(CSR_MSCRATCH, 3'b001, 5'd4, 32'h0000_1234, 1'b0, 32'h0, "wr_scratch");
      applyStimulus(CSR_MSCRATCH, 3'b011, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0000_1234, "rc_x0");
      readCsr(CSR_MSCRATCH, 32'h0000_1234, "rc_x0_kept");

      // mtvec alignment and unimplemented address
      applyStimulus(CSR_MTVEC, 3'b001, 5'd6, 32'h0000_0103, 1'b0, 32'h0000_0008, "wr_mtvec");
      readCsr(CSR_MTVEC, 32'h0000_0100, "mtvec_align");
      applyStimulus(12'h7C0, 3'b001, 5'd1, 32'h0000_0055, 1'b0, 32'h0, "wr_unimpl");
      readCsr(12'h7C0, 32'h0, "unimpl_zero");

      @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
